// File: rtl/mem_pkg.sv
// Shared types for the data-memory access sequencer: request opcodes,
// FSM states and default widths.
package mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mem_seq.sv
// Initiator side of the data-memory port: runs LOAD, STORE and ascending
// byte-wise COPY requests as one memory access per cycle.
module mem_seq
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_src,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] wr_addr_q;
  logic [LW-1:0] count_q;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          accept;
  op_e           req_op_e;

  assign req_op_e = op_e'(req_op);
  assign accept   = req_valid && (state_q == S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (req_op_e)
            OP_LOAD:  state_d = S_RD;
            OP_STORE: state_d = S_WR;
            OP_COPY:  state_d = (req_len != '0) ? S_RD : S_DONE;
            default:  state_d = S_DONE;
          endcase
        end
      end
      S_RD: begin
        mem_rd   = 1'b1;
        mem_addr = rd_addr_q;
        state_d  = (op_q == OP_COPY) ? S_WR : S_DONE;
      end
      S_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = buf_q;
        if (op_q == OP_COPY && count_q != LW'(1)) state_d = S_RD;
        else                                      state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request capture, read capture and copy stepping. Addresses
  // wrap naturally at 2**AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_LOAD;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      count_q   <= '0;
      buf_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= req_op_e;
            err_q     <= (req_op_e == OP_RSVD);
            rd_addr_q <= (req_op_e == OP_LOAD) ? req_addr : req_src;
            wr_addr_q <= req_addr;
            count_q   <= req_len;
            buf_q     <= req_wdata;
          end
        end
        S_RD: begin
          buf_q   <= mem_rdata;
          rdata_q <= mem_rdata;
        end
        S_WR: begin
          if (op_q == OP_COPY) begin
            count_q   <= count_q - LW'(1);
            rd_addr_q <= rd_addr_q + AW'(1);
            wr_addr_q <= wr_addr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: a table of requests with hand-computed results,
// plus handshake and reset-during-copy sequences against a 256-byte memory.
module tb_mem_seq;
  import mem_pkg::*;

  localparam int LIM = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_src, req_len, req_wdata;
  logic       done, err, busy;
  logic [7:0] rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd, mem_wr;

  logic [7:0] mem [256] = '{default: 8'h00};

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, cyc = 0;
  logic [7:0] last_rd_addr = '0, last_wr_addr = '0, last_wdata = '0;

  mem_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_src   (req_src),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin rd_cnt++; last_rd_addr = mem_addr; end
      if (mem_wr) begin wr_cnt++; last_wr_addr = mem_addr; last_wdata = mem_wdata; end
      if (done) done_cnt++;
      check("rd_wr_overlap", {31'd0, mem_rd && mem_wr}, 32'd0);
      if (!mem_rd && !mem_wr) check("idle_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
    end
  end

  always @(posedge clk) assert (!(mem_rd && mem_wr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < LIM) begin step(); n++; end
    if (n >= LIM) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < LIM) begin step(); lat++; end
    if (lat >= LIM) check("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    op_e        op;
    logic [7:0] addr, src, len, wdata;
    int         lat;
    logic       err;
    logic [7:0] rdata;
    int         nrd, nwr;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int lat, rd0, wr0, dn0, acc_prev, acc_now;
    logic [7:0] hs_addr [3];
    logic [7:0] hs_data [3];

    vecs = '{
      '{OP_STORE, 8'h10, 8'h00, 8'd0, 8'hA5, 1, 1'b0, 8'h00, 0, 1},
      '{OP_LOAD,  8'h10, 8'h00, 8'd0, 8'h00, 1, 1'b0, 8'hA5, 1, 0},
      '{OP_STORE, 8'h22, 8'h00, 8'd0, 8'h3C, 1, 1'b0, 8'hA5, 0, 1},
      '{OP_LOAD,  8'h22, 8'h00, 8'd0, 8'h00, 1, 1'b0, 8'h3C, 1, 0},
      '{OP_STORE, 8'hFE, 8'h00, 8'd0, 8'h11, 1, 1'b0, 8'h3C, 0, 1},
      '{OP_STORE, 8'hFF, 8'h00, 8'd0, 8'h22, 1, 1'b0, 8'h3C, 0, 1},
      '{OP_STORE, 8'h00, 8'h00, 8'd0, 8'h33, 1, 1'b0, 8'h3C, 0, 1},
      '{OP_STORE, 8'h01, 8'h00, 8'd0, 8'h44, 1, 1'b0, 8'h3C, 0, 1},
      '{OP_STORE, 8'h02, 8'h00, 8'd0, 8'h55, 1, 1'b0, 8'h3C, 0, 1},
      '{OP_COPY,  8'h40, 8'hFE, 8'd4, 8'h00, 8, 1'b0, 8'h44, 4, 4},
      '{OP_LOAD,  8'h43, 8'h00, 8'd0, 8'h00, 1, 1'b0, 8'h44, 1, 0},
      '{OP_LOAD,  8'h40, 8'h00, 8'd0, 8'h00, 1, 1'b0, 8'h11, 1, 0},
      '{OP_COPY,  8'h50, 8'h10, 8'd0, 8'h00, 0, 1'b0, 8'h11, 0, 0},
      '{OP_RSVD,  8'h60, 8'h10, 8'd3, 8'h99, 0, 1'b1, 8'h11, 0, 0},
      '{OP_COPY,  8'h41, 8'h40, 8'd3, 8'h00, 6, 1'b0, 8'h11, 3, 3},
      '{OP_LOAD,  8'h43, 8'h00, 8'd0, 8'h00, 1, 1'b0, 8'h11, 1, 0}
    };

    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_addr = '0; req_src = '0; req_len = '0; req_wdata = '0;
    #2;
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_outs", {8'd0, done, err, busy, mem_rd, mem_wr, rdata, mem_addr[2:0]}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      req_op = vecs[i].op; req_addr = vecs[i].addr; req_src = vecs[i].src;
      req_len = vecs[i].len; req_wdata = vecs[i].wdata; req_valid = 1'b1;
      wait_ready();
      rd0 = rd_cnt; wr0 = wr_cnt;
      step();
      req_valid = 1'b0;
      wait_done(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].rdata});
      check($sformatf("v%0d_nrd", i), rd_cnt - rd0, vecs[i].nrd);
      check($sformatf("v%0d_nwr", i), wr_cnt - wr0, vecs[i].nwr);
      if (vecs[i].op == OP_LOAD)
        check($sformatf("v%0d_rd_addr", i), {24'd0, last_rd_addr}, {24'd0, vecs[i].addr});
      if (vecs[i].op == OP_STORE)
        check($sformatf("v%0d_wr_bus", i), {16'd0, last_wr_addr, last_wdata},
              {16'd0, vecs[i].addr, vecs[i].wdata});
      step();
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    check("copy_wrap_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h11111111);
    check("copy_wrap_mem44", {24'd0, mem[8'h44]}, 32'd0);

    // Three LOADs with req_valid held high; a junk STORE is presented while busy.
    hs_addr = '{8'h10, 8'h22, 8'h43};
    hs_data = '{8'hA5, 8'h3C, 8'h11};
    wr0 = wr_cnt; dn0 = done_cnt; acc_prev = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_op = OP_LOAD; req_addr = hs_addr[k];
      wait_ready();
      step();
      acc_now = cyc;
      if (k > 0) check($sformatf("hs%0d_gap", k), acc_now - acc_prev, 3);
      acc_prev = acc_now;
      req_op = OP_STORE; req_addr = 8'hEE; req_wdata = 8'hFF;
      check($sformatf("hs%0d_busy", k), {30'd0, busy, req_ready}, 32'd2);
      wait_done(lat);
      check($sformatf("hs%0d_lat", k), lat, 1);
      check($sformatf("hs%0d_rdata", k), {24'd0, rdata}, {24'd0, hs_data[k]});
    end
    req_valid = 1'b0;
    step();
    check("hs_no_writes", wr_cnt - wr0, 0);
    check("hs_done_count", done_cnt - dn0, 3);
    check("hs_mem_ee", {24'd0, mem[8'hEE]}, 32'd0);

    // Reset in the middle of an 8-byte copy.
    req_op = OP_COPY; req_src = 8'h00; req_addr = 8'h80; req_len = 8'd8; req_valid = 1'b1;
    wait_ready();
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    dn0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_outs", {5'd0, done, err, busy, mem_rd, mem_wr, rdata, mem_addr, mem_wdata}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("mid_rst_no_done", done_cnt - dn0, 0);
    check("mid_rst_mem", {8'd0, mem[8'h80], mem[8'h81], mem[8'h82]}, 32'h00334400);

    req_op = OP_LOAD; req_addr = 8'h81; req_valid = 1'b1;
    wait_ready();
    step();
    req_valid = 1'b0;
    wait_done(lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_rdata", {24'd0, rdata}, 32'h44);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Memory-access sequencer: the initiator side of the data-memory port.
- Accepts load, store and block-copy requests from the core over a valid/ready handshake.
- Drives read-enable, write-enable, address and write data to the 256-byte data memory, one access per cycle.
- Returns load data, or a completion pulse, to the core.

Parameters:
AW, 8, address width; memory depth 2**AW bytes; address arithmetic wraps modulo 2**AW
DW, 8, data width
LW, 8, copy-length width; max copy 2**LW-1 bytes

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request (high only in IDLE)
req_op  in  2  00 LOAD, 01 STORE, 10 COPY, 11 reserved
req_addr  in  AW  LOAD/STORE address; COPY destination base
req_src  in  AW  COPY source base
req_len  in  LW  COPY byte count
req_wdata  in  DW  STORE data
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = reserved op
rdata  out  DW  last byte read; valid with done for LOAD
busy  out  1  state != IDLE
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_rdata  in  DW  memory read data, combinational from mem_addr while mem_rd=1

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - Internal address, count and buffer registers are cleared.
- Reset mid-operation aborts immediately. Bytes already written stay written. No done pulse is issued.
- States: IDLE, RD, WR, DONE.
- Accept: a request is taken on the rising edge where req_valid && req_ready. The sequencer latches op, addr, src, len and wdata at that edge. The request inputs are ignored at all other times.
- Transitions out of IDLE on accept:
  - LOAD -> RD.
  - STORE -> WR.
  - COPY with len>0 -> RD.
  - COPY with len=0 -> DONE.
  - Reserved op -> DONE with err=1.
- RD:
  - Drives mem_rd=1 and mem_addr = current read address.
  - Captures mem_rdata into the buffer and into rdata at the next edge.
  - LOAD -> DONE. COPY -> WR.
- WR:
  - Drives mem_wr=1, mem_addr = current write address, mem_wdata = buffer (STORE: latched wdata).
  - STORE -> DONE.
  - COPY: decrement count and increment both addresses (wrapping). If count becomes 0 -> DONE, otherwise -> RD.
- DONE: done=1 for exactly one cycle, then -> IDLE. err is 0 except for a reserved op.
- Latency, with accept at edge T:
  - done is high in the cycle after edge T+1 for LOAD and STORE.
  - COPY of N>0 bytes: done after edge T+2N.
  - COPY with len=0 and reserved op: done after edge T.
  - A back-to-back request is accepted at the edge that ends DONE's following IDLE cycle. Throughput is one request per (latency+1) cycles.
- Bus rules:
  - mem_rd and mem_wr are never high together.
  - mem_addr and mem_wdata are 0 whenever both enables are 0.
  - All memory outputs are decoded from registered state (no input-to-output combinational path).
- rdata holds the last read byte until the next RD capture. For COPY it equals the last byte copied.
- Wrap-around: addresses increment modulo 2**AW, so a copy crossing 0xFF continues at 0x00.
- Overlap: the copy is strictly ascending, one byte at a time. With dst in (src, src+len) the source is overwritten progressively and earlier bytes are replicated. This is the required behaviour, not an error.
- busy = (state != IDLE). req_ready = (state == IDLE).

Decomposition:
- Shared package mem_pkg:
  - op enum (OP_LOAD=2'b00, OP_STORE=2'b01, OP_COPY=2'b10, OP_RSVD=2'b11).
  - State enum.
  - AW/DW defaults.
- No sub-module. Single FSM plus a datapath of address, count and buffer registers in one file.

Test Plan:
- Reset mid-copy: start COPY src=0x00 dst=0x80 len=8; assert rst_n=0 after 5 cycles -> outputs zero at once, req_ready=1, no done, mem[0x80..0x81] written, mem[0x82..] untouched.
- LOAD: mem[0x10]=0xA5; LOAD addr=0x10 accepted at T -> mem_rd=1 with mem_addr=0x10 for one cycle; done=1 and rdata=0xA5 after T+1; err=0.
- STORE: STORE addr=0x22 wdata=0x3C -> exactly one mem_wr cycle at 0x22 with data 0x3C; done after T+1; a subsequent LOAD of 0x22 returns 0x3C.
- COPY with wrap: src=0xFE, dst=0x40, len=4, mem[FE,FF,00,01]=11,22,33,44 -> mem[40..43]=11,22,33,44; 8 alternating rd/wr cycles; done after T+8; rdata=0x44.
- Edge ops: COPY len=0 -> done after T, no mem_rd/mem_wr; op=11 -> done with err=1, no memory access.
- Handshake: hold req_valid high with 3 queued LOADs -> each accepted only when req_ready=1; req_valid while busy is ignored; mem_rd/mem_wr never overlap (assertion).
